// File: rtl/fpu_cmd_seq.sv
// rtl/fpu_cmd_seq.sv - single-command sequencer driving the fpu memory/control pins
//
// Purpose: accepts one host command at a time (arithmetic op, host SRAM write,
// or illegal op), walks the fpu through arm / operand fetch / execute, waits
// for fpu_done (bounded by TIMEOUT) and returns a one-beat status response.
//
// Ports:
//   clk, rstp                    clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/src1/src2/dst/rm      command fields, cmd_wdata for host write (op 7)
//   addr1/addr2/addr3, opcode_in, round_mp, inp, ld, enable   fpu pins (registered)
//   fpu_done, fpu_flags          fpu completion and status flags
//   rsp_valid/rsp_ready          response handshake
//   rsp_flags, rsp_err           captured fpu flags, 00 ok / 01 timeout / 10 illegal op

module fpu_cmd_seq #(
  parameter logic [4:0]  SCRATCH_ADDR = 5'd31,
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned FETCH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstp,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_src1,
  input  logic [4:0]  cmd_src2,
  input  logic [4:0]  cmd_dst,
  input  logic [2:0]  cmd_rm,
  input  logic [31:0] cmd_wdata,
  output logic [4:0]  addr1,
  output logic [4:0]  addr2,
  output logic [4:0]  addr3,
  output logic [2:0]  opcode_in,
  output logic [2:0]  round_mp,
  output logic [31:0] inp,
  output logic        ld,
  output logic        enable,
  input  logic        fpu_done,
  input  logic [7:0]  fpu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_flags,
  output logic [1:0]  rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FETCH,
    S_EXEC,
    S_WRITE,
    S_ILLEGAL,
    S_RESP
  } state_t;

  localparam logic [3:0] FETCH_LAST = 4'(FETCH_CYCLES - 1);
  localparam logic [3:0] EXEC_LAST  = 4'(TIMEOUT - 1);

  state_t     state_q;
  logic [3:0] cnt_q;     // fetch-cycle counter in FETCH, done timer in EXEC
  logic [4:0] src1_q;
  logic [4:0] src2_q;
  logic [4:0] dst_q;
  logic       accept;

  assign accept = cmd_valid && cmd_ready;

  // Outputs are assigned on the edge that enters a state, so the registered
  // pin values always match the state currently held.
  always_ff @(posedge clk) begin
    if (!rstp) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      src1_q    <= 5'd0;
      src2_q    <= 5'd0;
      dst_q     <= 5'd0;
      enable    <= 1'b1;
      ld        <= 1'b1;
      addr1     <= SCRATCH_ADDR;
      addr2     <= 5'd0;
      addr3     <= SCRATCH_ADDR;
      opcode_in <= 3'd0;
      round_mp  <= 3'd0;
      inp       <= 32'd0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_flags <= 8'd0;
      rsp_err   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            src1_q    <= cmd_src1;
            src2_q    <= cmd_src2;
            dst_q     <= cmd_dst;
            if (cmd_op <= 3'd4) begin
              // enable=0/ld=0 on the scratch word clears the fpu done counter
              state_q   <= S_ARM;
              enable    <= 1'b0;
              ld        <= 1'b0;
              addr1     <= SCRATCH_ADDR;
              inp       <= 32'd0;
              opcode_in <= cmd_op;
              round_mp  <= cmd_rm;
            end else if (cmd_op == 3'd7) begin
              state_q <= S_WRITE;
              enable  <= 1'b0;
              ld      <= 1'b0;
              addr1   <= cmd_dst;
              inp     <= cmd_wdata;
            end else begin
              // Illegal ops leave the pins in the safe idle encoding and spend
              // one cycle here so their latency matches a host write.
              state_q <= S_ILLEGAL;
            end
          end
        end

        S_ARM: begin
          state_q <= S_FETCH;
          cnt_q   <= 4'd0;
          enable  <= 1'b1;
          ld      <= 1'b1;
          addr1   <= src1_q;
          addr2   <= src2_q;
          addr3   <= dst_q;
        end

        S_FETCH: begin
          // fpu_done is ignored here; ld=1 already blocks any SRAM write
          if (cnt_q == FETCH_LAST) begin
            state_q <= S_EXEC;
            cnt_q   <= 4'd0;
            ld      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_EXEC: begin
          // done is tested before the timer so a late done still wins
          if (fpu_done) begin
            state_q   <= S_RESP;
            rsp_flags <= fpu_flags;
            rsp_err   <= 2'b00;
            rsp_valid <= 1'b1;
            ld        <= 1'b1;
            addr1     <= SCRATCH_ADDR;
          end else if (cnt_q == EXEC_LAST) begin
            state_q   <= S_RESP;
            rsp_flags <= 8'd0;
            rsp_err   <= 2'b01;
            rsp_valid <= 1'b1;
            ld        <= 1'b1;
            addr1     <= SCRATCH_ADDR;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        S_WRITE: begin
          state_q   <= S_RESP;
          rsp_flags <= 8'd0;
          rsp_err   <= 2'b00;
          rsp_valid <= 1'b1;
          enable    <= 1'b1;
          ld        <= 1'b1;
          addr1     <= SCRATCH_ADDR;
        end

        S_ILLEGAL: begin
          state_q   <= S_RESP;
          rsp_flags <= 8'd0;
          rsp_err   <= 2'b10;
          rsp_valid <= 1'b1;
        end

        S_RESP: begin
          if (rsp_ready) begin
            // back to the reset pin encoding so IDLE looks the same every time
            state_q   <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            addr1     <= SCRATCH_ADDR;
            addr2     <= 5'd0;
            addr3     <= SCRATCH_ADDR;
            opcode_in <= 3'd0;
            round_mp  <= 3'd0;
            inp       <= 32'd0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// tb/tb_fpu_cmd_seq.sv - directed bench for fpu_cmd_seq with an fpu/SRAM stand-in and per-cycle expectation queue

module tb_fpu_cmd_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstp;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_src1, cmd_src2, cmd_dst;
  logic [2:0]  cmd_rm;
  logic [31:0] cmd_wdata;
  logic [4:0]  addr1, addr2, addr3;
  logic [2:0]  opcode_in, round_mp;
  logic [31:0] inp;
  logic        ld, enable;
  logic        fpu_done;
  logic [7:0]  fpu_flags;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_flags;
  logic [1:0]  rsp_err;

  fpu_cmd_seq dut (
    .clk(clk), .rstp(rstp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .cmd_rm(cmd_rm), .cmd_wdata(cmd_wdata),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .opcode_in(opcode_in), .round_mp(round_mp), .inp(inp),
    .ld(ld), .enable(enable),
    .fpu_done(fpu_done), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- fpu + SRAM stand-in ----------------
  logic [31:0] mem [32];
  logic [31:0] opa, opb;
  int          lat_cfg;     // EXEC cycle (1-based) on which done fires, 0 = never
  bit          glitch_cfg;  // spurious done while ld=1
  bit          clr_mem;
  int          ecnt;

  function automatic logic [39:0] eval(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  f;
    r = a ^ b;
    f = 8'h40;
    case (op)
      3'd0: if (a == 32'h3F800000 && b == 32'h40000000) begin r = 32'h40400000; f = 8'h00; end
      3'd1: if (a == 32'h3F800000 && b == 32'h40000000) begin r = 32'h40000000; f = 8'h00; end
      3'd2: if (b == 32'd0) begin r = 32'h7F800000; f = 8'h80; end
      3'd4: begin r = a; f = (a < b) ? 8'h01 : ((a == b) ? 8'h02 : 8'h04); end
      default: ;
    endcase
    return {r, f};
  endfunction

  logic [39:0] ev;
  assign ev = eval(opcode_in, opa, opb);

  always_comb begin
    fpu_done = 1'b0;
    if (enable === 1'b1 && ld === 1'b0 && lat_cfg != 0 && ecnt == lat_cfg - 1) fpu_done = 1'b1;
    if (enable === 1'b1 && ld === 1'b1 && glitch_cfg) fpu_done = 1'b1;
    fpu_flags = fpu_done ? ev[7:0] : 8'hA5;
  end

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      ecnt <= 0;
      opa  <= 32'd0;
      opb  <= 32'd0;
    end else if (enable === 1'b0 && ld === 1'b0) begin
      mem[addr1] <= inp;
      ecnt       <= 0;
    end else if (enable === 1'b1 && ld === 1'b1) begin
      opa <= mem[addr1];
      opb <= mem[addr2];
    end else if (enable === 1'b1 && ld === 1'b0) begin
      ecnt <= ecnt + 1;
      if (fpu_done) mem[addr3] <= ev[39:8];
    end
  end

  // ---------------- expectation queue ----------------
  typedef struct {
    string       tag;
    logic        en, ld;
    logic [4:0]  a1, a2, a3;
    bit          c23, copc, cinp;
    logic [2:0]  opc, rm;
    logic [31:0] inp;
    logic        crdy, rvld;
    logic [7:0]  flg;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input string tag, input logic en, input logic ldv, input logic [4:0] a1,
                              input logic crdy, input logic rvld);
    exp_t e;
    e.tag = tag; e.en = en; e.ld = ldv; e.a1 = a1; e.crdy = crdy; e.rvld = rvld;
    e.a2 = 5'd0; e.a3 = 5'd31; e.c23 = 1'b0; e.copc = 1'b0; e.cinp = 1'b0;
    e.opc = 3'd0; e.rm = 3'd0; e.inp = 32'd0; e.flg = 8'd0; e.err = 2'b00;
    return e;
  endfunction

  initial begin : compare_proc
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, " enable"},    32'(enable),    32'(e.en));
        chk({e.tag, " ld"},        32'(ld),        32'(e.ld));
        chk({e.tag, " addr1"},     32'(addr1),     32'(e.a1));
        chk({e.tag, " cmd_ready"}, 32'(cmd_ready), 32'(e.crdy));
        chk({e.tag, " rsp_valid"}, 32'(rsp_valid), 32'(e.rvld));
        if (e.c23) begin
          chk({e.tag, " addr2"}, 32'(addr2), 32'(e.a2));
          chk({e.tag, " addr3"}, 32'(addr3), 32'(e.a3));
        end
        if (e.copc) begin
          chk({e.tag, " opcode_in"}, 32'(opcode_in), 32'(e.opc));
          chk({e.tag, " round_mp"},  32'(round_mp),  32'(e.rm));
        end
        if (e.cinp) chk({e.tag, " inp"}, inp, e.inp);
        if (e.rvld) begin
          chk({e.tag, " rsp_flags"}, 32'(rsp_flags), 32'(e.flg));
          chk({e.tag, " rsp_err"},   32'(rsp_err),   32'(e.err));
        end
      end
    end
  end

  // ---------------- command driver ----------------
  logic [7:0] last_flags;
  logic [1:0] last_err;

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [2:0] rm, input logic [31:0] wd,
                         input int lat, input int hold, input bit keep_valid, input bit glitch);
    exp_t        e;
    int          n_exec, resp_start, k, guard;
    logic [7:0]  flg;
    logic [1:0]  err;
    logic [39:0] r;
    lat_cfg    = lat;
    glitch_cfg = glitch;
    @(negedge clk);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (cmd_ready !== 1'b1) begin
      chk({tag, " cmd_ready wait"}, 32'(cmd_ready), 32'd1);
      return;
    end
    k = 0;
    e = mk({tag, " IDLE"}, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0);
    e.c23 = 1'b1;
    exp_q.push_back(e); k++;
    if (op <= 3'd4) begin
      n_exec = (lat >= 1 && lat <= 15) ? lat : 15;
      if (lat >= 1 && lat <= 15) begin
        r = eval(op, mem[s1], mem[s2]);
        flg = r[7:0];
        err = 2'b00;
      end else begin
        flg = 8'd0;
        err = 2'b01;
      end
      e = mk({tag, " ARM"}, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0);
      e.c23 = 1'b1; e.copc = 1'b1; e.opc = op; e.rm = rm; e.cinp = 1'b1; e.inp = 32'd0;
      exp_q.push_back(e); k++;
      for (int i = 0; i < 2; i++) begin
        e = mk({tag, " FETCH"}, 1'b1, 1'b1, s1, 1'b0, 1'b0);
        e.c23 = 1'b1; e.a2 = s2; e.a3 = d; e.copc = 1'b1; e.opc = op; e.rm = rm;
        exp_q.push_back(e); k++;
      end
      for (int i = 0; i < n_exec; i++) begin
        e = mk({tag, " EXEC"}, 1'b1, 1'b0, s1, 1'b0, 1'b0);
        e.c23 = 1'b1; e.a2 = s2; e.a3 = d; e.copc = 1'b1; e.opc = op; e.rm = rm;
        exp_q.push_back(e); k++;
      end
    end else if (op == 3'd7) begin
      flg = 8'd0;
      err = 2'b00;
      e = mk({tag, " WRITE"}, 1'b0, 1'b0, d, 1'b0, 1'b0);
      e.c23 = 1'b1; e.cinp = 1'b1; e.inp = wd;
      exp_q.push_back(e); k++;
    end else begin
      flg = 8'd0;
      err = 2'b10;
      e = mk({tag, " ILLEGAL"}, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
      e.c23 = 1'b1;
      exp_q.push_back(e); k++;
    end
    resp_start = k;
    for (int i = 0; i <= hold; i++) begin
      e = mk({tag, " RESP"}, 1'b1, 1'b1, 5'd31, 1'b0, 1'b1);
      e.flg = flg; e.err = err;
      if (op <= 3'd4) begin e.copc = 1'b1; e.opc = op; e.rm = rm; end
      exp_q.push_back(e); k++;
    end
    cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_rm = rm; cmd_wdata = wd;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 1; i < k; i++) begin
      @(negedge clk);
      if (i == 1) cmd_valid = 1'b0;
      if (keep_valid && i == resp_start) cmd_valid = 1'b1;
      rsp_ready = (i >= resp_start + hold);
      if (i == resp_start) begin
        last_flags = rsp_flags;
        last_err   = rsp_err;
      end
    end
  endtask

  logic [31:0] snap [32];
  int          diffs;
  int          guard;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstp = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_src1 = 5'd0; cmd_src2 = 5'd0;
    cmd_dst = 5'd0; cmd_rm = 3'd0; cmd_wdata = 32'd0; rsp_ready = 1'b0;
    lat_cfg = 0; glitch_cfg = 1'b0; clr_mem = 1'b1;
    last_flags = 8'd0; last_err = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset enable",    32'(enable),    32'd1);
    chk("reset ld",        32'(ld),        32'd1);
    chk("reset addr1",     32'(addr1),     32'd31);
    chk("reset addr2",     32'(addr2),     32'd0);
    chk("reset addr3",     32'(addr3),     32'd31);
    chk("reset opcode_in", 32'(opcode_in), 32'd0);
    chk("reset round_mp",  32'(round_mp),  32'd0);
    chk("reset inp",       inp,            32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_flags", 32'(rsp_flags), 32'd0);
    chk("reset rsp_err",   32'(rsp_err),   32'd0);
    clr_mem = 1'b0;
    rstp    = 1'b1;

    run_cmd("wr2", 3'd7, 5'd0, 5'd0, 5'd2, 3'd0, 32'h3F800000, 0, 0, 1'b0, 1'b0);
    run_cmd("wr3", 3'd7, 5'd0, 5'd0, 5'd3, 3'd0, 32'h40000000, 0, 0, 1'b0, 1'b0);
    run_cmd("add", 3'd0, 5'd2, 5'd3, 5'd4, 3'd0, 32'd0, 3, 0, 1'b0, 1'b0);
    chk("add sram4",  mem[4], 32'h40400000);
    chk("add sram2",  mem[2], 32'h3F800000);
    chk("add sram3",  mem[3], 32'h40000000);
    chk("add flags",  32'(last_flags), 32'h00);
    chk("add err",    32'(last_err),   32'd0);

    run_cmd("div", 3'd2, 5'd2, 5'd5, 5'd6, 3'd1, 32'd0, 4, 0, 1'b0, 1'b1);
    chk("div flags", 32'(last_flags), 32'h80);
    chk("div err",   32'(last_err),   32'd0);
    chk("div sram6", mem[6], 32'h7F800000);

    snap = mem;
    run_cmd("ill5", 3'd5, 5'd2, 5'd3, 5'd2, 3'd0, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);
    chk("ill5 err", 32'(last_err), 32'd2);
    diffs = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== snap[i]) diffs++;
    chk("ill5 sram untouched", 32'(diffs), 32'd0);

    run_cmd("mul_to", 3'd1, 5'd2, 5'd3, 5'd7, 3'd2, 32'd0, 0, 0, 1'b0, 1'b0);
    chk("mul_to err",   32'(last_err),   32'd1);
    chk("mul_to flags", 32'(last_flags), 32'd0);
    chk("mul_to sram7", mem[7], 32'd0);

    run_cmd("mul_edge", 3'd1, 5'd2, 5'd3, 5'd9, 3'd0, 32'd0, 15, 0, 1'b0, 1'b0);
    chk("mul_edge err",   32'(last_err), 32'd0);
    chk("mul_edge sram9", mem[9], 32'h40000000);

    run_cmd("cmp_hold", 3'd4, 5'd2, 5'd3, 5'd10, 3'd0, 32'd0, 2, 10, 1'b1, 1'b0);
    chk("cmp_hold flags", 32'(last_flags), 32'h01);
    run_cmd("cmp_again", 3'd4, 5'd2, 5'd3, 5'd10, 3'd0, 32'd0, 1, 0, 1'b0, 1'b0);
    chk("cmp_again flags", 32'(last_flags), 32'h01);

    // reset while in EXEC
    lat_cfg = 0;
    glitch_cfg = 1'b0;
    @(negedge clk);
    cmd_op = 3'd1; cmd_src1 = 5'd2; cmd_src2 = 5'd3; cmd_dst = 5'd11; cmd_rm = 3'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(enable === 1'b1 && ld === 1'b0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rst reach exec", 32'(enable === 1'b1 && ld === 1'b0), 32'd1);
    repeat (3) @(negedge clk);
    rstp = 1'b0;
    @(negedge clk);
    chk("rst enable",    32'(enable),    32'd1);
    chk("rst ld",        32'(ld),        32'd1);
    chk("rst addr1",     32'(addr1),     32'd31);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    rstp = 1'b1;
    @(negedge clk);
    chk("post rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post rst enable",    32'(enable),    32'd1);
    chk("post rst ld",        32'(ld),        32'd1);
    chk("post rst sram11",    mem[11],        32'd0);

    run_cmd("wr8", 3'd7, 5'd0, 5'd0, 5'd8, 3'd0, 32'h12345678, 0, 0, 1'b0, 1'b0);
    chk("wr8 sram8", mem[8], 32'h12345678);
    @(negedge clk);
    #2;
    chk("final rsp_valid", 32'(rsp_valid), 32'd0);
    chk("final cmd_ready", 32'(cmd_ready), 32'd1);
    chk("final queue empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
